// File: rtl/ysyx_23060096_ifu.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> HOLD, minimum 3 cycles per instruction.
// Request is held until accepted; the instruction is held until the datapath commits it; halt stops for good.
module ysyx_23060096_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  input  logic              inst_ready,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              halt,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t state;

  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_HOLD);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            inst  <= imem_resp_data;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            if (halt) begin
              state <= S_HALT;
            end else begin
              // Fetch addresses are always word aligned.
              pc    <= next_pc & ~ADDR_W'(3);
              state <= S_REQ;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
